prn_check: RTL
==============

PRN_CHECK -- requirements
Module: prn_check

Interface
REQ-001 Parameter PRNSIZE, 10, LFSR length in bits (2..32).
REQ-002 Parameter POLY, 10'h204, feedback tap mask: feedback = XOR-reduce(POLY & sr).
REQ-003 Parameter LOCK_CNT, 16, consecutive correct predictions required to declare lock (1..255).
REQ-004 Parameter WINDOW, 64, chips per error-monitoring window in LOCKED (2..65535).
REQ-005 Parameter UNLOCK_ERR, 8, errors within one window that force loss of lock (1..WINDOW).
REQ-006 Port clk, input, 1, single clock; all logic rising-edge.
REQ-007 Port reset, input, 1, synchronous active-high reset.
REQ-008 Port clear, input, 1, synchronous restart of acquisition and counters.
REQ-009 Port chip_valid, input, 1, qualifies chip_in for one clk (same role as the generator's shift strobe).
REQ-010 Port chip_in, input, 1, received hard-decision chip.
REQ-011 Port state, output, 2, 0=SEARCH, 1=VERIFY, 2=LOCKED.
REQ-012 Port locked, output, 1, high while state==LOCKED.
REQ-013 Port err_pulse, output, 1, one-cycle pulse per mismatched chip in VERIFY or LOCKED.
REQ-014 Port err_count, output, 32, saturating count of mismatches while LOCKED.
REQ-015 Port chip_count, output, 32, saturating count of chips received while LOCKED.

Function
REQ-016 Register sr[PRNSIZE-1:0] shifts left, new bit entering at bit 0, only on chip_valid; predicted chip = XOR-reduce(POLY & sr).
REQ-017 SEARCH: each valid chip shifts chip_in into sr; fill counter increments; after PRNSIZE chips -> VERIFY on the cycle of the PRNSIZE-th chip.
REQ-018 SEARCH boundary: if the resulting sr is all-zero, stay in SEARCH and restart fill count at 0.
REQ-019 VERIFY: each valid chip compares chip_in to predicted; sr shifts in predicted (free-run, never chip_in).
REQ-020 VERIFY match: match counter increments; at LOCK_CNT matches -> LOCKED; window and error-window counters zeroed.
REQ-021 VERIFY mismatch: err_pulse; -> SEARCH with fill counter and match counter zeroed; that chip is not loaded.
REQ-022 LOCKED: sr free-runs on predicted; each valid chip increments chip_count and window counter; mismatch increments err_count and error-window counter and pulses err_pulse.
REQ-023 LOCKED: when error-window counter reaches UNLOCK_ERR -> SEARCH next cycle; err_count/chip_count retain values.
REQ-024 LOCKED: when window counter reaches WINDOW chips without unlock, both window counters return to 0 (error on the last chip counts in the expiring window).
REQ-025 err_pulse, state, locked, counters are registered: update in the cycle after the chip_valid cycle.
REQ-026 err_count and chip_count saturate at 32'hFFFF_FFFF, no wrap.
REQ-027 clear and chip_valid in same cycle: clear wins, chip discarded; clear -> SEARCH, all counters and sr zeroed.
REQ-028 chip_valid low: no state, sr or counter change; err_pulse low.

Reset
REQ-029 reset has priority over clear and chip_valid.
REQ-030 On reset: state=SEARCH, sr=0, all counters 0, locked=0, err_pulse=0, err_count=0, chip_count=0.
REQ-031 Reset mid-acquisition or mid-lock discards all progress; acquisition restarts from empty fill on the first valid chip after reset release.

Configuration
REQ-032 Macro PRN_CHECK_BER_CNT_EN defined: err_count and chip_count implemented per REQ-014/015/022/026.
REQ-033 Macro PRN_CHECK_BER_CNT_EN undefined: counters not implemented, err_count and chip_count tied to 0; lock FSM, err_pulse unaffected.

Verification
REQ-034 Reset, then clean x^10+x^3+1 stream from state 10'h3FF, chip_valid every cycle -> VERIFY after chip 10, locked high after chip 26, err_count=0.
REQ-035 Locked, single chip flipped at chip 100 -> one err_pulse, err_count=1, locked stays 1, chip_count keeps counting.
REQ-036 Locked, 8 chips flipped within one 64-chip window -> state SEARCH the cycle after the 8th error; err_count=8 held.
REQ-037 Stream of 10 zeros then valid sequence -> FSM remains in SEARCH through all-zero fill, then locks normally.
REQ-038 Error at chip 15 during VERIFY -> err_pulse, state SEARCH, relock after further 26 clean chips.
REQ-039 clear asserted with chip_valid while LOCKED -> state SEARCH, counters 0, chip discarded; build without PRN_CHECK_BER_CNT_EN -> err_count=chip_count=0 throughout.

Source files
------------

// File: rtl/prn_check.sv
// PN-sequence lock checker: acquires an LFSR stream, verifies it, then tracks chip errors while locked.
// Define PRN_CHECK_BER_CNT_EN to build the err_count/chip_count BER counters; otherwise they read 0.
module prn_check #(
    parameter int unsigned          PRNSIZE    = 10,
    parameter logic [PRNSIZE-1:0]   POLY       = 10'h204,
    parameter int unsigned          LOCK_CNT   = 16,
    parameter int unsigned          WINDOW     = 64,
    parameter int unsigned          UNLOCK_ERR = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        chip_valid,
    input  logic        chip_in,
    output logic [1:0]  state,
    output logic        locked,
    output logic        err_pulse,
    output logic [31:0] err_count,
    output logic [31:0] chip_count
);

    localparam int unsigned FILL_W = $clog2(PRNSIZE + 1);

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [PRNSIZE-1:0]  sr_q, sr_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [7:0]          match_q, match_d;
    logic [15:0]         win_q, win_d;
    logic [15:0]         ewin_q, ewin_d;
    logic [15:0]         ewin_next;
    logic                err_pulse_q, err_pulse_d;
    logic                locked_q, locked_d;
    logic                predicted;
    logic                mismatch;
    logic [PRNSIZE-1:0]  sr_fill;
    logic [PRNSIZE-1:0]  sr_free;

    assign predicted = ^(POLY & sr_q);
    assign mismatch  = chip_in ^ predicted;
    assign sr_fill   = {sr_q[PRNSIZE-2:0], chip_in};
    assign sr_free   = {sr_q[PRNSIZE-2:0], predicted};

    // Acquisition / verification / lock-tracking state machine
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        fill_d      = fill_q;
        match_d     = match_q;
        win_d       = win_q;
        ewin_d      = ewin_q;
        err_pulse_d = 1'b0;
        ewin_next   = ewin_q + 16'(mismatch);

        if (clear) begin
            state_d = ST_SEARCH;
            sr_d    = '0;
            fill_d  = '0;
            match_d = '0;
            win_d   = '0;
            ewin_d  = '0;
        end else if (chip_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    sr_d = sr_fill;
                    if (fill_q == FILL_W'(PRNSIZE - 1)) begin
                        fill_d  = '0;
                        match_d = '0;
                        // An all-zero register is a dead LFSR state; keep filling
                        if (sr_fill != '0) state_d = ST_VERIFY;
                    end else begin
                        fill_d = fill_q + FILL_W'(1);
                    end
                end
                ST_VERIFY: begin
                    if (mismatch) begin
                        err_pulse_d = 1'b1;
                        state_d     = ST_SEARCH;
                        fill_d      = '0;
                        match_d     = '0;
                    end else begin
                        sr_d = sr_free;
                        if (match_q == 8'(LOCK_CNT - 1)) begin
                            state_d = ST_LOCKED;
                            match_d = '0;
                            win_d   = '0;
                            ewin_d  = '0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end
                end
                ST_LOCKED: begin
                    sr_d        = sr_free;
                    err_pulse_d = mismatch;
                    if (ewin_next == 16'(UNLOCK_ERR)) begin
                        state_d = ST_SEARCH;
                        fill_d  = '0;
                        match_d = '0;
                        win_d   = '0;
                        ewin_d  = '0;
                    end else if (win_q == 16'(WINDOW - 1)) begin
                        win_d  = '0;
                        ewin_d = '0;
                    end else begin
                        win_d  = win_q + 16'd1;
                        ewin_d = ewin_next;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end

        locked_d = (state_d == ST_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SEARCH;
            sr_q        <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            win_q       <= '0;
            ewin_q      <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            win_q       <= win_d;
            ewin_q      <= ewin_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
        end
    end

    assign state     = state_q;
    assign locked    = locked_q;
    assign err_pulse = err_pulse_q;

`ifdef PRN_CHECK_BER_CNT_EN
    logic        cnt_inc;
    logic        err_inc;
    logic [31:0] err_count_q, err_count_d;
    logic [31:0] chip_count_q, chip_count_d;

    assign cnt_inc = chip_valid && !clear && (state_q == ST_LOCKED);
    assign err_inc = cnt_inc && mismatch;

    // Saturating BER counters; they survive loss of lock and are zeroed only by clear/reset
    always_comb begin
        err_count_d  = err_count_q;
        chip_count_d = chip_count_q;
        if (clear) begin
            err_count_d  = '0;
            chip_count_d = '0;
        end else begin
            if (cnt_inc && (chip_count_q != 32'hFFFF_FFFF)) chip_count_d = chip_count_q + 32'd1;
            if (err_inc && (err_count_q != 32'hFFFF_FFFF))  err_count_d  = err_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_count_q  <= '0;
            chip_count_q <= '0;
        end else begin
            err_count_q  <= err_count_d;
            chip_count_q <= chip_count_d;
        end
    end

    assign err_count  = err_count_q;
    assign chip_count = chip_count_q;
`else
    assign err_count  = '0;
    assign chip_count = '0;
`endif

endmodule
